div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Shares one sequential restoring divider among NUM_REQ requesters.
- Each requester has its own valid/ready request port and valid/ready response port.
- Fair selection is round-robin; only one division is outstanding at a time.
- Divide-by-zero is resolved locally without using the divider.
- Sits between the requesting engines and the single divider instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, divisor/remainder width; dividend/quotient width is DATA_W-1
ITER, DATA_W-1, iteration count driven on div_n (fits 7 bits)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester request accept (one-hot or zero)
req_dividend  input  NUM_REQ*(DATA_W-1)  packed dividends, requester i at slice i
req_divisor  input  NUM_REQ*DATA_W  packed divisors
rsp_valid  output  NUM_REQ  per-requester response valid (one-hot or zero)
rsp_ready  input  NUM_REQ  per-requester response accept
rsp_quotient  output  DATA_W-1  shared response quotient
rsp_remainder  output  DATA_W  shared response remainder
rsp_err  output  1  divide-by-zero flag for the current response
div_valid_src  output  1  operand valid to divider
div_ready_src  input  1  divider ready for operands
div_n  output  7  iteration count, constant ITER
div_dividend  output  DATA_W-1  operand to divider
div_divisor  output  DATA_W  operand to divider
div_valid_dst  input  1  divider result valid
div_ready_dst  output  1  result accept to divider
div_quotient  input  DATA_W-1  divider quotient
div_remainder  input  DATA_W  divider remainder
busy  output  1  high in any state other than IDLE
grant_id  output  $clog2(NUM_REQ)  index of the current owner

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (async, low) forces IDLE, ptr=0, grant_id=0, all operand/result registers 0.
  - All req_ready, rsp_valid, div_valid_src and div_ready_dst are 0; busy=0.
  - Reset mid-operation abandons the transaction; the divider shares the same reset.
- IDLE: combinational round-robin search of req_valid, starting at index ptr and wrapping.
  - Winner w gets req_ready[w]=1 in the same cycle; all other req_ready are 0.
  - On handshake: latch w, dividend and divisor.
  - Divisor==0: next state RESP with quotient={DATA_W-1{1}}, remainder=zero-extended dividend, err=1.
  - Divisor!=0: next state ISSUE with err=0.
- ISSUE: div_valid_src=1; operands come from the latch and are held stable.
  - Leave for WAIT on div_valid_src && div_ready_src.
- WAIT: div_ready_dst=1.
  - On div_valid_dst, capture div_quotient and div_remainder, then go to RESP.
- RESP: rsp_valid[grant_id]=1; rsp_quotient, rsp_remainder and rsp_err are driven from registers and held stable.
  - On rsp_ready[grant_id]: go to IDLE and set ptr=(grant_id+1) mod NUM_REQ.
  - rsp_ready bits of other requesters are ignored.
- No new request is accepted outside IDLE: single outstanding transaction, no bypass.
- Minimum latency, request handshake to rsp_valid:
  - normal: 2 cycles + divider latency;
  - divide-by-zero: 1 cycle.
- A request dropped by a requester before acceptance is simply not granted; ptr is unchanged.
- div_n=ITER at all times.
- rsp data outputs are 0 outside RESP.

Test Plan:
1. Req 2 only, dividend 100, divisor 7 -> req_ready[2] same cycle; one div_valid_src handshake; rsp_valid[2] with quotient 14, remainder 2, err 0; busy low afterward.
2. All four req_valid held high from reset -> grants in order 0,1,2,3, then 0 again; each divider transaction completes before the next req_ready.
3. ptr=2 (after serving req 1), reqs 0 and 3 pending -> req 3 is granted before req 0.
4. Req 1 with dividend 55, divisor 0 -> no div_valid_src; rsp_valid[1] one cycle after accept; quotient 0x7FFFFFFF, remainder 55, err 1.
5. Backpressure: div_ready_src low 5 cycles, then rsp_ready low 10 cycles -> operands and response held stable throughout; no req_ready asserted; completes correctly afterward.
6. Assert reset during WAIT -> all outputs 0 immediately (asynchronous); after release, IDLE with ptr=0; a fresh request 9/3 returns quotient 3, remainder 0.

Source files
------------

// File: rtl/div_share_arbiter.sv
// -----------------------------------------------------------------------------
// div_share_arbiter
//   Shares one sequential divider among NUM_REQ requesters. A round-robin
//   search picks the next requester while idle; only one division is in
//   flight at a time. Divide-by-zero is answered locally without touching
//   the divider.
//
// Ports
//   clk, reset                        clock, asynchronous active-low reset
//   req_valid/req_ready               per-requester request handshake
//   req_dividend/req_divisor          packed operands, requester i at slice i
//   rsp_valid/rsp_ready               per-requester response handshake
//   rsp_quotient/remainder/err        shared response data (0 outside RESP)
//   div_valid_src/div_ready_src       operand handshake to the divider
//   div_n, div_dividend, div_divisor  operands to the divider
//   div_valid_dst/div_ready_dst       result handshake from the divider
//   div_quotient, div_remainder       divider result
//   busy, grant_id                    status: not idle, current owner index
// -----------------------------------------------------------------------------
module div_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ITER    = DATA_W - 1,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int QW     = DATA_W - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*QW-1:0]   req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [QW-1:0]           rsp_quotient,
  output logic [DATA_W-1:0]       rsp_remainder,
  output logic                    rsp_err,
  output logic                    div_valid_src,
  input  logic                    div_ready_src,
  output logic [6:0]              div_n,
  output logic [QW-1:0]           div_dividend,
  output logic [DATA_W-1:0]       div_divisor,
  input  logic                    div_valid_dst,
  output logic                    div_ready_dst,
  input  logic [QW-1:0]           div_quotient,
  input  logic [DATA_W-1:0]       div_remainder,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [ID_W:0]      NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);

  state_t               state_q;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      grant_id_q;
  logic [QW-1:0]        opa_q;
  logic [DATA_W-1:0]    opb_q;
  logic [QW-1:0]        rsp_quo_q;
  logic [DATA_W-1:0]    rsp_rem_q;
  logic                 rsp_err_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 div_valid_src_q;
  logic                 div_ready_dst_q;
  logic                 busy_q;

  logic                 found_d;
  logic [ID_W-1:0]      win_d;
  logic [ID_W:0]        idx_d;
  logic [QW-1:0]        dvd_sel_d;
  logic [DATA_W-1:0]    dvs_sel_d;
  logic [NUM_REQ-1:0]   req_ready_d;

  // Round-robin search of req_valid starting at ptr_q, first hit wins.
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    idx_d   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_d = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx_d >= NUM_REQ_W) begin
        idx_d = idx_d - NUM_REQ_W;
      end else begin
        idx_d = idx_d;
      end
      if (!found_d && req_valid[idx_d[ID_W-1:0]]) begin
        found_d = 1'b1;
        win_d   = idx_d[ID_W-1:0];
      end else begin
        found_d = found_d;
      end
    end
  end

  // Operand mux for the current winner and the same-cycle grant.
  always_comb begin
    dvd_sel_d = req_dividend[int'(win_d)*QW +: QW];
    dvs_sel_d = req_divisor[int'(win_d)*DATA_W +: DATA_W];
    if (state_q == S_IDLE && found_d) begin
      req_ready_d = ONE_HOT0 << win_d;
    end else begin
      req_ready_d = '0;
    end
  end

  // Transaction FSM with registered outputs; response data is cleared on
  // leaving RESP so the shared response bus reads 0 whenever it is not valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      ptr_q           <= '0;
      grant_id_q      <= '0;
      opa_q           <= '0;
      opb_q           <= '0;
      rsp_quo_q       <= '0;
      rsp_rem_q       <= '0;
      rsp_err_q       <= 1'b0;
      rsp_valid_q     <= '0;
      div_valid_src_q <= 1'b0;
      div_ready_dst_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            grant_id_q <= win_d;
            opa_q      <= dvd_sel_d;
            opb_q      <= dvs_sel_d;
            busy_q     <= 1'b1;
            if (dvs_sel_d == '0) begin
              // Divide-by-zero never reaches the divider.
              state_q     <= S_RESP;
              rsp_quo_q   <= '1;
              rsp_rem_q   <= {1'b0, dvd_sel_d};
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= ONE_HOT0 << win_d;
            end else begin
              state_q         <= S_ISSUE;
              rsp_err_q       <= 1'b0;
              div_valid_src_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (div_ready_src) begin
            state_q         <= S_WAIT;
            div_valid_src_q <= 1'b0;
            div_ready_dst_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (div_valid_dst) begin
            state_q         <= S_RESP;
            div_ready_dst_q <= 1'b0;
            rsp_quo_q       <= div_quotient;
            rsp_rem_q       <= div_remainder;
            rsp_valid_q     <= ONE_HOT0 << grant_id_q;
          end
        end
        S_RESP: begin
          // Only the owner's rsp_ready matters.
          if (rsp_ready[grant_id_q]) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_quo_q   <= '0;
            rsp_rem_q   <= '0;
            rsp_err_q   <= 1'b0;
            ptr_q       <= (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_d;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = rsp_quo_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_err       = rsp_err_q;
  assign div_valid_src = div_valid_src_q;
  assign div_ready_dst = div_ready_dst_q;
  assign div_n         = 7'(ITER);
  assign div_dividend  = opa_q;
  assign div_divisor   = opb_q;
  assign busy          = busy_q;
  assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural divider attached.
module tb_div_share_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int QW = DW - 1;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*QW-1:0] req_dividend = '0;
  logic [N*DW-1:0] req_divisor = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [QW-1:0]   rsp_quotient;
  logic [DW-1:0]   rsp_remainder;
  logic            rsp_err;
  logic            div_valid_src;
  logic            div_ready_src;
  logic [6:0]      div_n;
  logic [QW-1:0]   div_dividend;
  logic [DW-1:0]   div_divisor;
  logic            div_valid_dst;
  logic            div_ready_dst;
  logic [QW-1:0]   div_quotient;
  logic [DW-1:0]   div_remainder;
  logic            busy;
  logic [1:0]      grant_id;

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int hs0;

  // divider model
  logic          src_en = 1'b1;
  logic          d_busy, d_vld;
  logic [QW-1:0] d_a;
  logic [DW-1:0] d_b;
  int            d_cnt;

  always #5 clk = ~clk;

  div_share_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .div_valid_src(div_valid_src), .div_ready_src(div_ready_src), .div_n(div_n),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_valid_dst(div_valid_dst), .div_ready_dst(div_ready_dst),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .busy(busy), .grant_id(grant_id)
  );

  assign div_ready_src = src_en && !d_busy;
  assign div_valid_dst = d_vld;

  // Behavioural divider: fixed latency, shares the reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_busy <= 1'b0; d_vld <= 1'b0; d_a <= '0; d_b <= '0; d_cnt <= 0;
      div_quotient <= '0; div_remainder <= '0;
    end else if (!d_busy && div_valid_src && div_ready_src) begin
      d_busy <= 1'b1; d_a <= div_dividend; d_b <= div_divisor; d_cnt <= LAT;
    end else if (d_busy && !d_vld) begin
      if (d_cnt == 0) begin
        d_vld <= 1'b1;
        div_quotient  <= QW'(DW'(d_a) / d_b);
        div_remainder <= DW'(d_a) % d_b;
      end else begin
        d_cnt <= d_cnt - 1;
      end
    end else if (d_vld && div_ready_dst) begin
      d_vld <= 1'b0; d_busy <= 1'b0;
    end
  end

  // Operand handshake counter.
  always @(posedge clk) begin
    if (reset && div_valid_src && div_ready_src) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic set_op(input int id, input logic [QW-1:0] a, input logic [DW-1:0] b);
    req_dividend[id*QW +: QW] = a;
    req_divisor[id*DW +: DW]  = b;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_rsp(input logic [N-1:0] exp, input string tag);
    int n;
    n = 0;
    while (rsp_valid !== exp && n < 40) begin
      cyc();
      n++;
    end
    chk({tag, "_rspv"}, 64'(rsp_valid), 64'(exp));
  endtask

  // Full transaction for requester id; other req_valid bits left as the caller set them.
  task automatic serve(input int id, input logic [QW-1:0] a, input logic [DW-1:0] b,
                       input logic [QW-1:0] eq, input logic [DW-1:0] er, input string tag);
    logic [N-1:0] oh;
    oh = 4'b0001 << id;
    set_op(id, a, b);
    #1;
    chk({tag, "_grant"}, 64'(req_ready), 64'(oh));
    cyc();
    req_valid[id] = 1'b0;
    chk({tag, "_noready"}, 64'(req_ready), 64'd0);
    wait_rsp(oh, tag);
    chk({tag, "_quo"}, 64'(rsp_quotient), 64'(eq));
    chk({tag, "_rem"}, 64'(rsp_remainder), 64'(er));
    chk({tag, "_err"}, 64'(rsp_err), 64'd0);
    rsp_ready[id] = 1'b1;
    cyc();
    rsp_ready = '0;
    chk({tag, "_done"}, 64'({busy, rsp_valid, rsp_quotient}), 64'd0);
  endtask

  logic [QW-1:0] t2_a [4] = '{31'd20, 31'd30, 31'd40, 31'd50};
  logic [DW-1:0] t2_b [4] = '{32'd3, 32'd4, 32'd5, 32'd6};
  logic [QW-1:0] t2_q [4] = '{31'd6, 31'd7, 31'd8, 31'd8};
  logic [DW-1:0] t2_r [4] = '{32'd2, 32'd2, 32'd0, 32'd2};

  initial begin
    // reset state
    cyc();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_div_vsrc", 64'(div_valid_src), 64'd0);
    chk("rst_div_rdst", 64'(div_ready_dst), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_quo", 64'(rsp_quotient), 64'd0);
    chk("div_n", 64'(div_n), 64'd31);
    for (int i = 0; i < N; i++) set_op(i, t2_a[i], t2_b[i]);
    reset = 1'b1;

    // test 2: all four requesting, grants 0,1,2,3,0
    rsp_ready = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_grant%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      cyc();
      chk($sformatf("t2_hold%0d", k), 64'(req_ready), 64'd0);
      wait_rsp(4'b0001 << (k % 4), $sformatf("t2_%0d", k));
      chk($sformatf("t2_quo%0d", k), 64'(rsp_quotient), 64'(t2_q[k % 4]));
      chk($sformatf("t2_rem%0d", k), 64'(rsp_remainder), 64'(t2_r[k % 4]));
      cyc();
    end
    req_valid = '0;
    rsp_ready = '0;
    cyc();

    // test 1: req 2 alone, 100/7
    hs0 = hs_cnt;
    set_op(2, 31'd100, 32'd7);
    #1;
    chk("t1_grant", 64'(req_ready), 64'(4'b0100));
    cyc();
    req_valid = '0;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_vsrc", 64'(div_valid_src), 64'd1);
    chk("t1_opa", 64'(div_dividend), 64'd100);
    chk("t1_opb", 64'(div_divisor), 64'd7);
    wait_rsp(4'b0100, "t1");
    chk("t1_quo", 64'(rsp_quotient), 64'd14);
    chk("t1_rem", 64'(rsp_remainder), 64'd2);
    chk("t1_err", 64'(rsp_err), 64'd0);
    chk("t1_hs", 64'(hs_cnt - hs0), 64'd1);
    rsp_ready[2] = 1'b1;
    cyc();
    rsp_ready = '0;
    chk("t1_idle", 64'({busy, rsp_valid, rsp_quotient}), 64'd0);

    // test 3: serve req 1 (ptr -> 2), then 0 and 3 pending: 3 first
    serve(1, 31'd12, 32'd4, 31'd3, 32'd0, "t3a");
    set_op(0, 31'd64, 32'd5);
    serve(3, 31'd77, 32'd7, 31'd11, 32'd0, "t3b");
    serve(0, 31'd64, 32'd5, 31'd12, 32'd4, "t3c");

    // test 5: backpressure on divider and response (ptr = 1)
    src_en = 1'b0;
    set_op(0, 31'd1, 32'd1);
    set_op(3, 31'd1000, 32'd33);
    #1;
    chk("t5_grant", 64'(req_ready), 64'(4'b1000));
    cyc();
    req_valid[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_vsrc", 64'(div_valid_src), 64'd1);
      chk("t5_ops", 64'({div_dividend, div_divisor}), {31'd1000, 32'd33});
      chk("t5_noready", 64'(req_ready), 64'd0);
      cyc();
    end
    src_en = 1'b1;
    rsp_ready = 4'b0001;
    wait_rsp(4'b1000, "t5");
    for (int i = 0; i < 10; i++) begin
      chk("t5_rhold", 64'({rsp_valid, rsp_err}), 64'({4'b1000, 1'b0}));
      chk("t5_rdata", 64'({rsp_quotient, rsp_remainder}), {31'd30, 32'd10});
      chk("t5_noready2", 64'(req_ready), 64'd0);
      cyc();
    end
    rsp_ready = 4'b1000;
    req_valid = '0;
    cyc();
    rsp_ready = '0;
    chk("t5_drop", 64'({busy, req_ready}), 64'd0);

    // test 4: divide by zero on req 1 (ptr = 0)
    hs0 = hs_cnt;
    set_op(1, 31'd55, 32'd0);
    #1;
    chk("t4_grant", 64'(req_ready), 64'(4'b0010));
    cyc();
    req_valid = '0;
    chk("t4_rspv", 64'(rsp_valid), 64'(4'b0010));
    chk("t4_quo", 64'(rsp_quotient), 64'h7FFF_FFFF);
    chk("t4_rem", 64'(rsp_remainder), 64'd55);
    chk("t4_err", 64'(rsp_err), 64'd1);
    chk("t4_vsrc", 64'(div_valid_src), 64'd0);
    rsp_ready[1] = 1'b1;
    cyc();
    rsp_ready = '0;
    chk("t4_hs", 64'(hs_cnt - hs0), 64'd0);
    chk("t4_idle", 64'({busy, rsp_err}), 64'd0);

    // test 6: reset during WAIT (ptr = 2 beforehand)
    set_op(2, 31'd5000, 32'd7);
    cyc();
    req_valid = '0;
    for (int i = 0; i < 20 && div_ready_dst !== 1'b1; i++) cyc();
    chk("t6_wait", 64'(div_ready_dst), 64'd1);
    chk("t6_gid", 64'(grant_id), 64'd2);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rdst", 64'(div_ready_dst), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_outs", 64'({rsp_valid, div_valid_src, req_ready, grant_id}), 64'd0);
    cyc();
    reset = 1'b1;
    set_op(3, 31'd20, 32'd5);
    serve(1, 31'd9, 32'd3, 31'd3, 32'd0, "t6a");
    serve(3, 31'd20, 32'd5, 31'd4, 32'd0, "t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
